// File: rtl/maxpool2x2_stream_if.sv
// Valid/ready stream bundle used on both sides of the 2x2 max-pool stage.
// The master drives valid and data; the slave drives ready.
interface maxpool2x2_stream_if #(
  parameter int N = 14
);
  logic         valid;
  logic         ready;
  logic [N-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order activation stream.
// Even columns park the pixel in pair_max; odd columns form the horizontal
// max. Even rows store that max in a half-width line buffer; odd rows combine
// it with the stored value and load the single-entry output register.
module maxpool2x2_stream #(
  parameter int N     = 14,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  maxpool2x2_stream_if.slave    din,
  maxpool2x2_stream_if.master   dout,
  output logic                  frame_done
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // Position counters and datapath registers
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [N-1:0]     pair_max_reg, pair_max_next;
  logic [N-1:0]     dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             frame_done_reg, frame_done_next;

  // Half-width line buffer holding the horizontal maxima of the even row
  logic [N-1:0]     line_buf [HALF_W];
  logic [HALF_W-1:0] lb_we;
  logic [LB_W-1:0]  lb_idx;
  logic [N-1:0]     lb_rd;

  // Per-beat decode
  logic             accept;
  logic             col_odd;
  logic             row_odd;
  logic             col_end;
  logic             row_end;
  logic             lb_wr;
  logic             win_done;
  logic [N-1:0]     hmax;
  logic [N-1:0]     vmax;

  // The output register is a plain single-entry stage: input stalls only
  // while a result is held and the consumer is not taking it.
  assign din.ready  = ~dout_valid_reg | dout.ready;
  assign dout.valid = dout_valid_reg;
  assign dout.data  = dout_reg;
  assign frame_done = frame_done_reg;

  assign accept  = din.valid & din.ready;
  assign col_odd = col_reg[0];
  assign row_odd = row_reg[0];
  assign col_end = (col_reg == COL_LAST);
  assign row_end = (row_reg == ROW_LAST);

  // Column pair index; col is even-width so col>>1 always lies inside the buffer
  assign lb_idx = LB_W'(col_reg >> 1);
  assign lb_rd  = line_buf[lb_idx];

  // Unsigned compares; ties resolve to either operand with the same value
  assign hmax = (din.data > pair_max_reg) ? din.data : pair_max_reg;
  assign vmax = (hmax > lb_rd) ? hmax : lb_rd;

  assign lb_wr    = accept & col_odd & ~row_odd;
  assign win_done = accept & col_odd & row_odd;

  // One write-enable per line-buffer entry, decoded from the pair index
  genvar gi;
  generate
    for (gi = 0; gi < HALF_W; gi++) begin : g_lb_we
      assign lb_we[gi] = lb_wr && (lb_idx == LB_W'(gi));
    end
  endgenerate

  // Line-buffer storage; never reset since each entry is written before it is read
  always_ff @(posedge clk) begin
    for (int i = 0; i < HALF_W; i++) begin
      if (lb_we[i]) begin
        line_buf[i] <= hmax;
      end
    end
  end

  // Next-state for counters, pair register and output stage
  always_comb begin
    col_next        = col_reg;
    row_next        = row_reg;
    pair_max_next   = pair_max_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg & ~dout.ready;
    frame_done_next = 1'b0;

    if (accept) begin
      if (col_end) begin
        col_next = '0;
        row_next = row_end ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end

      if (!col_odd) begin
        pair_max_next = din.data;
      end
    end

    // A completing window overrides any drain in the same cycle, so a
    // consumer holding ready high sees back-to-back results without bubbles.
    if (win_done) begin
      dout_next       = vmax;
      dout_valid_next = 1'b1;
      frame_done_next = col_end & row_end;
    end
  end

  // State registers with synchronous reset; a mid-frame reset drops the partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg        <= '0;
      row_reg        <= '0;
      pair_max_reg   <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      pair_max_reg   <= pair_max_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      frame_done_reg <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream on a 4x4 frame, 14-bit samples.
// Expected results come from a frame-level window-max model kept in queues.
module tb_maxpool2x2_stream;

  localparam int N = 14;
  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst;
  logic frame_done;

  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.N(N)) din_bus ();
  maxpool2x2_stream_if #(.N(N)) dout_bus ();

  maxpool2x2_stream #(.N(N), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din_bus),
    .dout       (dout_bus),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  bit exp_last_q[$];
  int frame [NPIX];

  int beats    = 0;
  int fd_count = 0;
  bit strict_fd  = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: max of each 2x2 window of the frame, windows in raster order
  task automatic model_frame();
    int m;
    for (int r = 0; r < H; r += 2) begin
      for (int c = 0; c < W; c += 2) begin
        m = frame[r*W + c];
        if (frame[r*W + c + 1] > m)     m = frame[r*W + c + 1];
        if (frame[(r+1)*W + c] > m)     m = frame[(r+1)*W + c];
        if (frame[(r+1)*W + c + 1] > m) m = frame[(r+1)*W + c + 1];
        exp_q.push_back(m);
        exp_last_q.push_back((r == H - 2) && (c == W - 2));
      end
    end
  endtask

  // Monitor: counts beats and frame_done pulses, checks every output handshake
  always @(negedge clk) begin
    int e;
    bit l;
    if (!rst) begin
      if (din_bus.valid && din_bus.ready) beats++;
      if (frame_done) fd_count++;
      if (dout_bus.valid && dout_bus.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", dout_bus.data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          l = exp_last_q.pop_front();
          $display("out dout=%0d exp=%0d frame_done=%0d", dout_bus.data, e, frame_done);
          check("dout", dout_bus.data, e);
          if (strict_fd) check("frame_done_align", frame_done, l);
        end
      end
    end
  end

  // Random consumer backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (rand_ready) dout_bus.ready = 1'($urandom_range(0, 1));
  end

  // All driving tasks start and end at posedge+1
  task automatic send_pixel(input int v, input int gap_pct);
    bit ok;
    while ($urandom_range(0, 99) < gap_pct) begin
      @(posedge clk); #1;
    end
    din_bus.valid = 1'b1;
    din_bus.data  = N'(v);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (din_bus.ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("din_ready_timeout", 0, 1);
    @(posedge clk); #1;
    din_bus.valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct);
    for (int i = 0; i < NPIX; i++) send_pixel(frame[i], gap_pct);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NPIX; i++) frame[i] = int'($urandom_range(0, 16383));
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_bus.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int b0;
    int held;
    bit seen;

    rst = 1'b1;
    din_bus.valid  = 1'b0;
    din_bus.data   = '0;
    dout_bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_dout_valid", dout_bus.valid, 0);
    check("rst_dout", dout_bus.data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_din_ready", din_bus.ready, 1);
    @(posedge clk); #1;

    // Ramp 0..15 -> 5, 7, 13, 15 with frame_done on the last
    for (int i = 0; i < NPIX; i++) frame[i] = i;
    model_frame();
    strict_fd = 1'b1;
    fd0 = fd_count;
    send_frame(0);
    wait_drain("ramp_drain");
    check("ramp_fd_count", fd_count - fd0, 1);

    // Tie in the vertical compare
    rand_frame();
    frame[0] = 3; frame[1] = 9; frame[W] = 2; frame[W + 1] = 9;
    model_frame();
    fd0 = fd_count;
    send_frame(0);
    wait_drain("tie_drain");
    check("tie_fd_count", fd_count - fd0, 1);

    // Backpressure after the first result
    strict_fd = 1'b0;
    rand_frame();
    model_frame();
    dout_bus.ready = 1'b0;
    b0 = beats;
    fork
      send_frame(0);
      begin
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (dout_bus.valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("stall_seen_valid", seen, 1);
        repeat (5) @(negedge clk);
        held = int'(dout_bus.data);
        check("stall_dout_valid", dout_bus.valid, 1);
        check("stall_dout", dout_bus.data, exp_q[0]);
        check("stall_din_ready", din_bus.ready, 0);
        check("stall_beats", beats - b0, 6);
        repeat (4) @(negedge clk);
        check("stall_hold_dout", dout_bus.data, held);
        check("stall_hold_beats", beats - b0, 6);
        @(posedge clk); #1;
        dout_bus.ready = 1'b1;
      end
    join
    wait_drain("stall_drain");
    check("stall_total_beats", beats - b0, NPIX);

    // Three back-to-back random frames with input gaps and random ready
    rand_ready = 1'b1;
    fd0 = fd_count;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      model_frame();
      send_frame(50);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    dout_bus.ready = 1'b1;
    wait_drain("random_drain");
    check("random_fd_count", fd_count - fd0, 3);

    // Mid-frame reset after 6 pixels; the held result must be discarded
    dout_bus.ready = 1'b0;
    rand_frame();
    for (int i = 0; i < 6; i++) send_pixel(frame[i], 0);
    do_reset();
    dout_bus.ready = 1'b1;
    @(negedge clk);
    check("midrst_dout_valid", dout_bus.valid, 0);
    check("midrst_dout", dout_bus.data, 0);
    @(posedge clk); #1;
    strict_fd = 1'b1;
    rand_frame();
    model_frame();
    fd0 = fd_count;
    send_frame(0);
    wait_drain("midrst_drain");
    check("midrst_fd_count", fd_count - fd0, 1);

    // Full-scale and all-zero frames
    for (int i = 0; i < NPIX; i++) frame[i] = 16383;
    model_frame();
    send_frame(0);
    wait_drain("max_drain");
    for (int i = 0; i < NPIX; i++) frame[i] = 0;
    model_frame();
    send_frame(0);
    wait_drain("zero_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
